// File: rtl/cpu_run_ctrl_if.sv
// Host-side streaming channels of the run controller: load words in, dump words out.
interface cpu_run_ctrl_if;
    logic       in_valid;
    logic [9:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [9:0] out_data;
    logic       out_ready;

    // Host drives load words and dump back-pressure
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Controller accepts load words and produces dump words
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Load/run/dump sequencer for the 10-bit CPU: owns the CPU reset and the data-RAM port mux.
module cpu_run_ctrl #(
    parameter int unsigned MAX_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [9:0]           i_load_len,
    input  logic [9:0]           i_dump_base,
    input  logic [9:0]           i_dump_len,
    cpu_run_ctrl_if.slave        host,
    output logic                 o_cpu_rst,
    input  logic                 i_cpu_halted,
    input  logic                 i_cpu_ram_we,
    input  logic [9:0]           i_cpu_ram_addr,
    input  logic [9:0]           i_cpu_ram_wdata,
    output logic [9:0]           o_cpu_ram_rdata,
    output logic                 o_ram_we,
    output logic [9:0]           o_ram_addr,
    output logic [9:0]           o_ram_wdata,
    input  logic [9:0]           i_ram_rdata,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic [15:0]          o_cycle_count
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StDump, StDone} state_e;

    localparam logic [15:0] LastCycle = 16'(MAX_CYCLES - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [9:0]  r_idx;
    logic [9:0]  r_load_len;
    logic [9:0]  r_dump_base;
    logic [9:0]  r_dump_len;
    logic [15:0] r_cycle_count;
    logic        r_timeout;
    logic        r_cpu_rst;

    logic w_start_ok;
    logic w_load_acc;
    logic w_load_last;
    logic w_dump_empty;
    logic w_dump_acc;
    logic w_dump_last;
    logic w_halt;
    logic w_time_up;

    assign w_start_ok   = (r_state == StIdle) && i_start;
    assign w_load_acc   = (r_state == StLoad) && host.in_valid;
    assign w_load_last  = w_load_acc && (r_idx == r_load_len - 10'd1);
    assign w_dump_empty = (r_dump_len == '0);
    assign w_dump_acc   = (r_state == StDump) && !w_dump_empty && host.out_ready;
    assign w_dump_last  = w_dump_acc && (r_idx == r_dump_len - 10'd1);
    assign w_halt       = (r_state == StRun) && i_cpu_halted;
    // Halt has priority over timeout when both land in the same cycle
    assign w_time_up    = (r_state == StRun) && !i_cpu_halted && (r_cycle_count == LastCycle);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (i_start) w_state_next = (i_load_len == '0) ? StRun : StLoad;
            StLoad: if (w_load_last) w_state_next = StRun;
            StRun:  if (w_halt || w_time_up) w_state_next = StDump;
            StDump: if (w_dump_empty || w_dump_last) w_state_next = StDone;
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Sequence parameters, word index, run statistics and the registered CPU reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= '0;
            r_load_len    <= '0;
            r_dump_base   <= '0;
            r_dump_len    <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
            r_cpu_rst     <= 1'b1;
        end else begin
            // CPU runs only while the next state is RUN, so the edge lines up with entry/exit
            r_cpu_rst <= (w_state_next != StRun);
            if (w_start_ok) begin
                r_load_len    <= i_load_len;
                r_dump_base   <= i_dump_base;
                r_dump_len    <= i_dump_len;
                r_idx         <= '0;
                r_cycle_count <= '0;
                r_timeout     <= 1'b0;
            end else if (w_load_acc || w_dump_acc) begin
                r_idx <= r_idx + 10'd1;
            end else if (w_halt || w_time_up) begin
                r_idx <= '0;
            end
            if ((r_state == StRun) && !i_cpu_halted) begin
                r_cycle_count <= r_cycle_count + 16'd1;
            end
            if (w_halt) begin
                r_timeout <= 1'b0;
            end else if (w_time_up) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // RAM port mux and host channel outputs per state
    always_comb begin
        host.in_ready   = 1'b0;
        host.out_valid  = 1'b0;
        host.out_data   = '0;
        o_ram_we        = 1'b0;
        o_ram_addr      = '0;
        o_ram_wdata     = '0;
        o_cpu_ram_rdata = '0;
        unique case (r_state)
            StLoad: begin
                host.in_ready = 1'b1;
                o_ram_we      = host.in_valid;
                o_ram_addr    = r_idx;
                o_ram_wdata   = host.in_data;
            end
            StRun: begin
                o_ram_we        = i_cpu_ram_we;
                o_ram_addr      = i_cpu_ram_addr;
                o_ram_wdata     = i_cpu_ram_wdata;
                o_cpu_ram_rdata = i_ram_rdata;
            end
            StDump: begin
                // 10-bit add wraps the window past address 1023 back to 0
                o_ram_addr     = r_dump_base + r_idx;
                host.out_valid = !w_dump_empty;
                host.out_data  = w_dump_empty ? 10'd0 : i_ram_rdata;
            end
            default: ;
        endcase
    end

    assign o_busy        = (r_state != StIdle);
    assign o_done        = (r_state == StDone);
    assign o_cpu_rst     = r_cpu_rst;
    assign o_timeout     = r_timeout;
    assign o_cycle_count = r_cycle_count;

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the 10-bit single-cycle CPU and its data RAM. Holds the CPU in reset while a host streams an initial image into data RAM, then releases the CPU and counts cycles until it halts or times out. It then re-asserts CPU reset and streams a window of RAM back to the host. It sits between the CPU's data-memory port and the RAM instance and owns the RAM mux and the CPU reset.

## Interface
Parameters:
- MAX_CYCLES, 1000: run-phase timeout in cycles, range 1..65535.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a load/run/dump sequence; ignored unless the block is idle.
- load_len  in  10  number of words to load from address 0; sampled on an accepted start.
- dump_base  in  10  first RAM address to dump; sampled on an accepted start.
- dump_len  in  10  number of words to dump; sampled on an accepted start.
- in_valid  in  1  host load word valid.
- in_data  in  10  host load word.
- in_ready  out  1  block accepts the load word.
- out_valid  out  1  dump word valid.
- out_data  out  10  dump word.
- out_ready  in  1  host accepts the dump word.
- cpu_rst  out  1  reset to the CPU.
- cpu_halted  in  1  CPU halted flag.
- cpu_ram_we  in  1  CPU data-memory write enable.
- cpu_ram_addr  in  10  CPU data-memory address.
- cpu_ram_wdata  in  10  CPU data-memory write data.
- cpu_ram_rdata  out  10  read data returned to the CPU.
- ram_we  out  1  RAM write enable.
- ram_addr  out  10  RAM address.
- ram_wdata  out  10  RAM write data.
- ram_rdata  in  10  RAM read data; asynchronous read.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a sequence.
- timeout  out  1  the last run ended on timeout; sticky until the next accepted start.
- cycle_count  out  16  cycles spent in RUN during the last sequence.

## Operation
- FSM states: IDLE, LOAD, RUN, DUMP, DONE.
- Reset values: state IDLE, cpu_rst=1, done=0, timeout=0, cycle_count=0, all internal counters 0.
- IDLE:
  - cpu_rst=1, in_ready=0, out_valid=0, ram_we=0, ram_addr=0.
  - On start: latch the three length/base inputs, clear cycle_count, timeout and the index counter.
  - Next state is LOAD, or RUN if load_len=0.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: ram_we=1, ram_addr=idx, ram_wdata=in_data, then idx increments.
  - The cycle that accepts word load_len-1 goes to RUN.
  - in_valid low stalls indefinitely with no write.
- RUN:
  - cpu_rst=0. The RAM port is a transparent mux to the CPU: ram_we/addr/wdata = cpu_ram_*, cpu_ram_rdata = ram_rdata.
  - Outside RUN, cpu_ram_rdata=0 and CPU RAM signals are ignored.
  - Each cycle with cpu_halted=0, cycle_count increments.
  - cpu_halted=1 sampled: go to DUMP, timeout=0.
  - Else if cycle_count==MAX_CYCLES-1: cycle_count becomes MAX_CYCLES, go to DUMP, timeout=1.
  - Halt and timeout in the same cycle: halt wins.
- DUMP:
  - cpu_rst=1.
  - ram_addr = dump_base+idx mod 1024 (wraps 1023 to 0), ram_we=0.
  - out_valid=1, out_data=ram_rdata (combinational, stable while stalled).
  - On out_ready: idx increments. Acceptance of word dump_len-1 goes to DONE.
  - dump_len=0: DUMP lasts one cycle with out_valid=0, then DONE.
  - idx clears on entry to DUMP.
- DONE: done=1 for exactly one cycle, then IDLE. cycle_count and timeout hold.
- Arithmetic:
  - Address adds are 10-bit modulo.
  - idx is 10 bits. load_len/dump_len of 0..1023 are supported; 1024 is not expressible.
- Async rst mid-sequence: immediate return to IDLE with reset values. Partially written RAM content is not restored.

## Timing
- start sampled in cycle 0: busy=1 and state LOAD from cycle 1.
- One load word is written per accepted handshake, zero bubbles.
- cpu_rst is registered: it falls in the first RUN cycle and rises in the first DUMP cycle.
- The CPU halt flag asserts one edge after its HALT instruction. The controller reaches DUMP one edge after sampling it.
- Dump data is valid in the same cycle as out_valid; throughput is one word per cycle with out_ready held high.
- done is asserted one cycle after the final dump handshake. IDLE is reached on the following edge, and start is accepted again from then.

## Test plan
- Reset, then idle for 5 cycles: cpu_rst=1, busy=0, ram_we=0, in_ready=0, out_valid=0, done=0.
- Load 3 words 0x011, 0x022, 0x3FF with in_valid gaps: RAM[0..2] hold those values, one write per handshake, and RUN is entered on the edge after the third accept.
- Program halts after 7 run cycles; dump_base=0, dump_len=3, out_ready always high: cycle_count=7, timeout=0, out_data sequence 0x011, 0x022, 0x3FF, then done pulses once.
- MAX_CYCLES=20 with a non-halting CPU: DUMP is entered with cycle_count=20, timeout=1 and cpu_rst=1.
- dump_base=1022, dump_len=4 with out_ready toggling: ram_addr sequence is 1022, 1023, 0, 1, and out_data is held stable while out_ready=0.
- Edge cases:
  - load_len=0 goes straight to RUN.
  - start during RUN is ignored.
  - rst asserted mid-LOAD returns to IDLE with cpu_rst=1; a new start restarts at address 0.
